display_value_formatter: RTL and testbench
==========================================

Name: display_value_formatter

Overview:
- Upstream feeder of the VGA/PS2 display top: converts a binary value written by the CPU into the twelve digit codes, point and symbol bytes the VGA digit renderer consumes.
- Iterative double-dabble binary-to-BCD converter with leading-zero blanking, sign extraction and a valid/ready handshake.
- Display outputs are held registers, updated atomically only when a conversion completes, so the renderer never sees a partial value.

Parameters:
- DATA_W, 32, width of binary input; max supported 39. The magnitude must fit in 12 BCD digits.
- BLANK_CODE, 8'd10, digit code the renderer draws as an empty cell.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request a conversion.
- in_ready  out  1  converter idle; a request is accepted on a rising edge where in_valid && in_ready.
- in_value  in  DATA_W  binary value.
- in_signed  in  1  1 = treat in_value as two's complement.
- in_dp  in  4  fractional digit count, 0..11. Values >11 are clamped to 11.
- done  out  1  one-cycle pulse; outputs have just been updated.
- number1..number12  out  8 each  digit codes, 0..9 or BLANK_CODE. number1 is the least significant digit.
- point  out  8  decimal point position. 0 = none; k = point between number(k+1) and number(k).
- symbol  out  8  8'd0 = no sign; 8'd1 = minus.

Behaviour:
- Reset (async, any state, including mid-conversion):
  - State goes to IDLE.
  - in_ready=1, done=0.
  - number1=0, number2..12=BLANK_CODE, point=0, symbol=0.
  - In-flight conversion is discarded.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - in_ready=1.
  - On acceptance edge, capture:
    - neg = in_signed & in_value[DATA_W-1].
    - mag = neg ? -in_value : in_value, DATA_W-bit unsigned. The most negative value yields its correct magnitude, e.g. -2^31 -> 2147483648.
    - Clamped dp.
    - Clear the 48-bit BCD accumulator and the shift counter.
  - Next state SHIFT.
- SHIFT, one bit per cycle, DATA_W cycles:
  - Each cycle, add 3 to every BCD nibble >=5, then shift {bcd, mag} left by one.
  - Counter reaches DATA_W-1 -> LATCH.
- LATCH, one cycle:
  - Register the outputs.
  - msd = index of the highest nonzero nibble, or 1 if the value is 0.
  - keep = max(msd, dp+1).
  - number_i = nibble_i for i<=keep, BLANK_CODE otherwise.
  - point = dp.
  - symbol = 1 iff neg and magnitude != 0. No negative zero.
  - Next state IDLE.
- done/in_ready timing: done=1 and in_ready=1 in the cycle after the LATCH edge.
- Latency: outputs change DATA_W+1 edges after the acceptance edge (33 for default).
- Back-to-back: a new request may be accepted in the same cycle done is high. There are no dead cycles.
- in_valid while in_ready=0 is ignored; it is not queued. in_value/in_signed/in_dp are don't-care after acceptance.
- Between conversions all display outputs hold their last values.
- No arithmetic overflow is possible: 12 nibbles cover 2^39-1. DATA_W > 39 is illegal; flag with an elaboration-time check.

Test Plan:
- Reset then idle -> number1=0, number2..12=10, point=0, symbol=0, in_ready=1, done=0.
- in_value=32'd1234, in_signed=0, in_dp=0 -> done exactly 33 edges after acceptance; number4..1=1,2,3,4; number5..12=10; symbol=0.
- in_value=32'hFFFFFFFB (-5), in_signed=1, in_dp=2 -> number3..1=0,0,5; number4..12=10; point=2; symbol=1. The same value with in_signed=0 -> digits 4294967291, symbol=0.
- in_value=32'h80000000, in_signed=1 -> digits 2147483648, symbol=1. in_value=0, in_signed=1 -> number1=0, symbol=0.
- Assert in_valid with 99 while busy, then request 7 on the done cycle -> 99 never appears; 7 is accepted back-to-back and displayed 33 edges later.
- Drop rst to 0 at SHIFT cycle 15 of a conversion of 555 -> outputs immediately take reset values, no done pulse. After release, a fresh request converts correctly.

Source files
------------

// File: rtl/display_value_formatter_if.sv
// rtl/display_value_formatter_if.sv - request handshake and held display outputs of the value formatter
interface display_value_formatter_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_value;
   logic              in_signed;
   logic [3:0]        in_dp;
   logic              done;
   logic [7:0]        number1;
   logic [7:0]        number2;
   logic [7:0]        number3;
   logic [7:0]        number4;
   logic [7:0]        number5;
   logic [7:0]        number6;
   logic [7:0]        number7;
   logic [7:0]        number8;
   logic [7:0]        number9;
   logic [7:0]        number10;
   logic [7:0]        number11;
   logic [7:0]        number12;
   logic [7:0]        point;
   logic [7:0]        symbol;

   modport master (
      output in_valid, in_value, in_signed, in_dp,
      input  in_ready, done, point, symbol,
      input  number1, number2, number3, number4, number5, number6,
      input  number7, number8, number9, number10, number11, number12
   );

   modport slave (
      input  in_valid, in_value, in_signed, in_dp,
      output in_ready, done, point, symbol,
      output number1, number2, number3, number4, number5, number6,
      output number7, number8, number9, number10, number11, number12
   );
endinterface

// File: rtl/display_value_formatter.sv
// rtl/display_value_formatter.sv - iterative double-dabble binary to blanked 12-digit display codes
module display_value_formatter #(
   parameter int         DATA_W     = 32,
   parameter logic [7:0] BLANK_CODE = 8'd10
) (
   input logic                      clk,
   input logic                      rst_n,
   display_value_formatter_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   generate
      if (DATA_W < 1 || DATA_W > 39) begin : g_bad_width
         $error("display_value_formatter: DATA_W must be 1..39 to fit 12 BCD digits");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              in_ready_c;
   logic              accept;
   logic              last_bit;

   logic [47:0]       bcd;
   logic [47:0]       bcd_adj;
   logic [DATA_W-1:0] mag;
   logic              neg;
   logic [3:0]        dp;
   logic [CNT_W-1:0]  cnt;

   logic              cap_neg;
   logic [3:0]        cap_dp;
   logic [3:0]        msd;
   logic [3:0]        keep;
   logic [7:0]        digit_d [12];

   logic [7:0]        num_q [12];
   logic [7:0]        point_q;
   logic [7:0]        symbol_q;
   logic              done_q;

   assign last_bit = (cnt == CNT_W'(DATA_W - 1));
   assign accept   = in_ready_c & bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = SHIFT;
         end
         SHIFT:   if (last_bit) state_nxt = LATCH;
         LATCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cap_neg = bus.in_signed & bus.in_value[DATA_W-1];
   assign cap_dp  = (bus.in_dp > 4'd11) ? 4'd11 : bus.in_dp;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 12; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Digits above the most significant one stay visible while the point needs them.
   always_comb begin
      msd = 4'd1;
      for (int i = 0; i < 12; i++) begin
         if (bcd[4*i +: 4] != 4'd0) msd = 4'(i + 1);
      end
      keep = (msd > dp + 4'd1) ? msd : dp + 4'd1;
      for (int i = 0; i < 12; i++) begin
         digit_d[i] = (4'(i + 1) <= keep) ? {4'd0, bcd[4*i +: 4]} : BLANK_CODE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd <= '0;
         mag <= '0;
         neg <= 1'b0;
         dp  <= 4'd0;
         cnt <= '0;
      end else if (accept) begin
         bcd <= '0;
         mag <= cap_neg ? -bus.in_value : bus.in_value;
         neg <= cap_neg;
         dp  <= cap_dp;
         cnt <= '0;
      end else if (state == SHIFT) begin
         {bcd, mag} <= {bcd_adj[46:0], mag, 1'b0};
         cnt        <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q[0] <= 8'd0;
         for (int i = 1; i < 12; i++) num_q[i] <= BLANK_CODE;
         point_q  <= 8'd0;
         symbol_q <= 8'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state == LATCH);
         if (state == LATCH) begin
            for (int i = 0; i < 12; i++) num_q[i] <= digit_d[i];
            point_q  <= {4'd0, dp};
            symbol_q <= (neg && (bcd != 48'd0)) ? 8'd1 : 8'd0;
         end
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.done     = done_q;
   assign bus.point    = point_q;
   assign bus.symbol   = symbol_q;
   assign bus.number1  = num_q[0];
   assign bus.number2  = num_q[1];
   assign bus.number3  = num_q[2];
   assign bus.number4  = num_q[3];
   assign bus.number5  = num_q[4];
   assign bus.number6  = num_q[5];
   assign bus.number7  = num_q[6];
   assign bus.number8  = num_q[7];
   assign bus.number9  = num_q[8];
   assign bus.number10 = num_q[9];
   assign bus.number11 = num_q[10];
   assign bus.number12 = num_q[11];
endmodule

// File: tb/tb_display_value_formatter.sv
// tb/tb_display_value_formatter.sv - vector table, corner sequences and random model check of the formatter
module tb_display_value_formatter;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   display_value_formatter_if #(.DATA_W(32)) dvf_if ();

   display_value_formatter #(.DATA_W(32), .BLANK_CODE(8'd10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dvf_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      bit          sgn;
      int          dp;
      string       exp_digits;
      logic [7:0]  exp_point;
      logic [7:0]  exp_symbol;
   } vec_t;

   function automatic logic [95:0] str2dig(input string s);
      logic [95:0] d;
      byte c;
      for (int i = 0; i < 12; i++) begin
         c = s[11-i];
         d[8*i +: 8] = (c == "_") ? 8'd10 : 8'(c - "0");
      end
      return d;
   endfunction

   function automatic logic [95:0] got_digits();
      return {dvf_if.number12, dvf_if.number11, dvf_if.number10, dvf_if.number9,
              dvf_if.number8, dvf_if.number7, dvf_if.number6, dvf_if.number5,
              dvf_if.number4, dvf_if.number3, dvf_if.number2, dvf_if.number1};
   endfunction

   // Reference: decimal expansion by repeated division on a 64-bit magnitude.
   function automatic void model(input logic [31:0] v, input bit s, input int dp_in,
                                 output logic [95:0] dig, output logic [7:0] pt,
                                 output logic [7:0] sym);
      longint m;
      longint t;
      int     d;
      int     nd;
      int     keep;
      bit     ng;
      ng = s && v[31];
      m  = ng ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
      d  = (dp_in > 11) ? 11 : dp_in;
      nd = 1;
      for (t = m; t >= 10; t = t / 10) nd++;
      keep = (nd > d + 1) ? nd : d + 1;
      t = m;
      for (int i = 0; i < 12; i++) begin
         dig[8*i +: 8] = (i < keep) ? 8'(t % 10) : 8'd10;
         t = t / 10;
      end
      pt  = 8'(d);
      sym = (ng && m != 0) ? 8'd1 : 8'd0;
   endfunction

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic start(input logic [31:0] v, input bit s, input int dp_in);
      @(negedge clk);
      dvf_if.in_value  = v;
      dvf_if.in_signed = s;
      dvf_if.in_dp     = 4'(dp_in);
      dvf_if.in_valid  = 1'b1;
      @(posedge clk);
      #1 dvf_if.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (dvf_if.done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic check_outputs(input string name, input logic [95:0] dig,
                                input logic [7:0] pt, input logic [7:0] sym);
      check({name, ".digits"}, got_digits(), dig);
      check({name, ".point"}, {88'd0, dvf_if.point}, {88'd0, pt});
      check({name, ".symbol"}, {88'd0, dvf_if.symbol}, {88'd0, sym});
   endtask

   vec_t        vecs [10];
   int          lat;
   int          done_cnt;
   logic [95:0] e_dig;
   logic [7:0]  e_pt;
   logic [7:0]  e_sym;
   logic [31:0] rv;
   bit          rs;
   int          rd;

   initial begin
      vecs[0] = '{32'd1234,       1'b0, 0,  "________1234", 8'd0,  8'd0};
      vecs[1] = '{32'hFFFFFFFB,   1'b1, 2,  "_________005", 8'd2,  8'd1};
      vecs[2] = '{32'hFFFFFFFB,   1'b0, 0,  "__4294967291", 8'd0,  8'd0};
      vecs[3] = '{32'h80000000,   1'b1, 0,  "__2147483648", 8'd0,  8'd1};
      vecs[4] = '{32'd0,          1'b1, 0,  "___________0", 8'd0,  8'd0};
      vecs[5] = '{32'd0,          1'b0, 15, "000000000000", 8'd11, 8'd0};
      vecs[6] = '{32'hFFFFFFFF,   1'b1, 3,  "________0001", 8'd3,  8'd1};
      vecs[7] = '{32'h7FFFFFFF,   1'b1, 5,  "__2147483647", 8'd5,  8'd0};
      vecs[8] = '{32'd100,        1'b0, 12, "000000000100", 8'd11, 8'd0};
      vecs[9] = '{32'd9,          1'b0, 0,  "___________9", 8'd0,  8'd0};

      rst_n            = 1'b0;
      dvf_if.in_valid  = 1'b0;
      dvf_if.in_value  = '0;
      dvf_if.in_signed = 1'b0;
      dvf_if.in_dp     = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset", str2dig("___________0"), 8'd0, 8'd0);
      check("reset.in_ready", {95'd0, dvf_if.in_ready}, 96'd1);
      check("reset.done", {95'd0, dvf_if.done}, 96'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle.in_ready", {95'd0, dvf_if.in_ready}, 96'd1);
      check_outputs("idle", str2dig("___________0"), 8'd0, 8'd0);

      for (int i = 0; i < 10; i++) begin
         start(vecs[i].value, vecs[i].sgn, vecs[i].dp);
         wait_done(lat);
         check($sformatf("vec%0d.latency", i), 96'(lat), 96'd33);
         check_outputs($sformatf("vec%0d", i), str2dig(vecs[i].exp_digits),
                       vecs[i].exp_point, vecs[i].exp_symbol);
      end

      // Request while busy is dropped; a request on the done cycle goes straight in.
      start(32'd1234, 1'b0, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      dvf_if.in_value = 32'd99;
      dvf_if.in_valid = 1'b1;
      check("busy.in_ready", {95'd0, dvf_if.in_ready}, 96'd0);
      repeat (3) @(negedge clk);
      dvf_if.in_valid = 1'b0;
      wait_done(lat);
      check("busy.latency", 96'(lat > 0), 96'd1);
      check_outputs("busy", str2dig("________1234"), 8'd0, 8'd0);
      check("b2b.in_ready", {95'd0, dvf_if.in_ready}, 96'd1);
      dvf_if.in_value  = 32'd7;
      dvf_if.in_signed = 1'b0;
      dvf_if.in_dp     = 4'd0;
      dvf_if.in_valid  = 1'b1;
      @(posedge clk);
      #1 dvf_if.in_valid = 1'b0;
      wait_done(lat);
      check("b2b.latency", 96'(lat), 96'd33);
      check_outputs("b2b", str2dig("___________7"), 8'd0, 8'd0);

      // Reset in the middle of a conversion.
      start(32'd555, 1'b0, 0);
      repeat (15) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_outputs("midreset", str2dig("___________0"), 8'd0, 8'd0);
      check("midreset.in_ready", {95'd0, dvf_if.in_ready}, 96'd1);
      check("midreset.done", {95'd0, dvf_if.done}, 96'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (dvf_if.done) done_cnt++;
      end
      check("midreset.no_done", 96'(done_cnt), 96'd0);
      check_outputs("midreset.hold", str2dig("___________0"), 8'd0, 8'd0);
      start(32'd42, 1'b0, 1);
      wait_done(lat);
      check("postreset.latency", 96'(lat), 96'd33);
      check_outputs("postreset", str2dig("__________42"), 8'd1, 8'd0);

      for (int i = 0; i < 40; i++) begin
         rv = $urandom;
         if (i % 4 == 0) rv = rv >> $urandom_range(0, 31);
         rs = 1'($urandom_range(0, 1));
         rd = int'($urandom_range(0, 15));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         model(rv, rs, rd, e_dig, e_pt, e_sym);
         start(rv, rs, rd);
         wait_done(lat);
         check($sformatf("rnd%0d.latency", i), 96'(lat), 96'd33);
         check_outputs($sformatf("rnd%0d(%h,%0d,%0d)", i, rv, rs, rd), e_dig, e_pt, e_sym);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
